// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : button_debounce
//  Purpose  : Synchronizes and debounces a bouncing mechanical push button.
//             Produces a clean level plus registered one-cycle press,
//             release and long-press pulses.
//  Revision : 1.0  initial release
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int LW = $clog2(LONG_CYCLES);

    localparam logic [DW-1:0] c_deb_last  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] c_long_last = LW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ARM_PRESS   = 2'd1,
        ST_HELD        = 2'd2,
        ST_ARM_RELEASE = 2'd3
    } state_t;

    state_t        state_q,     state_d;
    logic          sync1_q,     sync1_d;
    logic          sync2_q,     sync2_d;
    logic [DW-1:0] deb_cnt_q,   deb_cnt_d;
    logic [LW-1:0] long_cnt_q,  long_cnt_d;
    logic          long_fired_q, long_fired_d;
    logic          level_q,     level_d;
    logic          press_q,     press_d;
    logic          release_q,   release_d;
    logic          long_q,      long_d;

    // Next-state logic: synchronizer shift plus the debounce / long-press FSM.
    always_comb begin
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        state_d      = state_q;
        deb_cnt_d    = deb_cnt_q;
        long_cnt_d   = long_cnt_q;
        long_fired_d = long_fired_q;
        level_d      = level_q;
        press_d      = 1'b0;
        release_d    = 1'b0;
        long_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sync2_q) begin
                    state_d   = ST_ARM_PRESS;
                    deb_cnt_d = '0;
                end
            end
            ST_ARM_PRESS: begin
                if (!sync2_q) begin
                    state_d = ST_IDLE;
                end else if (deb_cnt_q == c_deb_last) begin
                    state_d      = ST_HELD;
                    level_d      = 1'b1;
                    press_d      = 1'b1;
                    long_cnt_d   = '0;
                    long_fired_d = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
            ST_HELD: begin
                // Long counter stops at its last value so it can never wrap
                // and re-trigger; long_fired limits the pulse to one per press.
                if ((long_cnt_q == c_long_last) && !long_fired_q) begin
                    long_d       = 1'b1;
                    long_fired_d = 1'b1;
                end
                if (long_cnt_q != c_long_last) begin
                    long_cnt_d = long_cnt_q + LW'(1);
                end
                if (!sync2_q) begin
                    state_d   = ST_ARM_RELEASE;
                    deb_cnt_d = '0;
                end
            end
            ST_ARM_RELEASE: begin
                // A bounce back to 1 resumes HELD with the long-press
                // progress kept intact.
                if (sync2_q) begin
                    state_d = ST_HELD;
                end else if (deb_cnt_q == c_deb_last) begin
                    state_d   = ST_IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            deb_cnt_q    <= '0;
            long_cnt_q   <= '0;
            long_fired_q <= 1'b0;
            level_q      <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_cnt_q    <= deb_cnt_d;
            long_cnt_q   <= long_cnt_d;
            long_fired_q <= long_fired_d;
            level_q      <= level_d;
            press_q      <= press_d;
            release_q    <= release_d;
            long_q       <= long_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_long    = long_q;

endmodule
`default_nettype wire

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of stable synchronized samples required to accept an edge (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter LONG_CYCLES, default 50000000, meaning the number of HELD cycles before a long-press pulse (1 s at 50 MHz).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-005 The block SHALL have port btn_raw, input, 1 bit: asynchronous mechanical button, active-high, bouncing.
REQ-006 The block SHALL have port btn_level, output, 1 bit: debounced button state.
REQ-007 The block SHALL have port btn_press, output, 1 bit: one-cycle pulse on accepted press; drives the LED chaser step/advance input.
REQ-008 The block SHALL have port btn_release, output, 1 bit: one-cycle pulse on accepted release.
REQ-009 The block SHALL have port btn_long, output, 1 bit: one-cycle pulse when a press has been held LONG_CYCLES cycles; drives the LED chaser clear input.

Function
REQ-010 btn_raw SHALL pass through a two-flop synchronizer (sync1, sync2); only sync2 SHALL feed the FSM.
REQ-011 The FSM SHALL have exactly four states: IDLE, ARM_PRESS, HELD, ARM_RELEASE.
REQ-012 IDLE: when sync2=1, the FSM SHALL go to ARM_PRESS with the debounce counter cleared to 0; otherwise it SHALL stay in IDLE.
REQ-013 ARM_PRESS: when sync2=0, the FSM SHALL return to IDLE with no output change; when sync2=1 and counter=DEBOUNCE_CYCLES-1, it SHALL go to HELD, set btn_level=1, pulse btn_press, and clear the long counter and the long_fired flag; otherwise the counter SHALL increment.
REQ-014 HELD: when sync2=0, the FSM SHALL go to ARM_RELEASE with the debounce counter cleared to 0; the long counter SHALL increment each HELD cycle.
REQ-015 HELD: when long counter=LONG_CYCLES-1 and long_fired=0, the block SHALL pulse btn_long once and set long_fired; the long counter SHALL then saturate, and no further btn_long SHALL occur until the next accepted press.
REQ-016 ARM_RELEASE: when sync2=1, the FSM SHALL return to HELD with the long counter and long_fired preserved (bounce ignored); when sync2=0 and counter=DEBOUNCE_CYCLES-1, it SHALL go to IDLE, set btn_level=0, and pulse btn_release; otherwise the counter SHALL increment.
REQ-017 All outputs SHALL be registered; btn_press, btn_release, and btn_long SHALL each be high for exactly one cycle per event and SHALL never be high in the same cycle.
REQ-018 Latency: counting the first edge sampling btn_raw=1 as edge 1, and with btn_raw held stable, btn_level and btn_press SHALL update at edge DEBOUNCE_CYCLES+3; release latency SHALL be symmetric.
REQ-019 Any pulse on btn_raw shorter than DEBOUNCE_CYCLES+1 synchronized samples SHALL produce no output change.
REQ-020 Counter widths SHALL be $clog2 of the respective parameter; parameters SHALL be at least 2; counters SHALL never wrap.

Reset
REQ-021 While reset=0 at a rising edge, the block SHALL set the FSM to IDLE and clear sync1, sync2, both counters, long_fired, btn_level, btn_press, btn_release, and btn_long to 0.
REQ-022 Reset asserted mid-operation (including HELD) SHALL abort immediately and SHALL NOT emit btn_release.
REQ-023 After reset deasserts with btn_raw already high, the block SHALL debounce it as a fresh press per REQ-018.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=16)
REQ-024 Clean press: btn_raw 0->1 before edge 1 and held -> btn_press=1 only after edge 7, btn_level=1 from edge 7.
REQ-025 Bounce: btn_raw toggles 1,0,1,0 every 2 cycles, then stays 1 -> no output during the toggling, then exactly one btn_press 7 edges after the final rise.
REQ-026 Long press: button held 40 cycles -> one btn_press at edge 7, one btn_long at edge 23, no second btn_long, and btn_release 7 edges after btn_raw falls.
REQ-027 Release bounce: in HELD, btn_raw 0 for 3 cycles then 1 -> no btn_release, btn_level stays 1, and the long counter continues.
REQ-028 Reset in HELD: reset=0 for 1 cycle at edge 15 -> all outputs 0 after edge 15, no btn_release; with btn_raw still 1, a new btn_press follows 7 edges after reset deasserts.
